async_packet_transmitter_q: RTL and testbench

Parametrised, queued serializer for the one-way inter-board link. It accepts whole datagrams through a valid/ready handshake into a small message FIFO. Each datagram is sent LSB-first as PKT_W-bit packets, each qualified by a one-cycle strobe, with a frame-last marker and a programmable inter-frame gap. It sits between the game-state producer and the board-to-board pins, all on clk_send.

---
 rtl/async_link_pkg.sv | 19 +
 rtl/msg_fifo.sv | 53 +++++
 rtl/async_packet_transmitter_q.sv | 111 +++++++++++
 tb/tb_async_packet_transmitter_q.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/async_link_pkg.sv
// Shared definitions for the inter-board serial link (transmitter and receiver).
package async_link_pkg;

  // Link data lines; the matching receiver uses the same default.
  localparam int unsigned DEF_PKT_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } tx_state_e;

  // Number of packets needed to carry a msg_w-bit datagram.
  function automatic int unsigned npkt(input int unsigned msg_w, input int unsigned pkt_w);
    return (msg_w + pkt_w - 1) / pkt_w;
  endfunction

endpackage

// File: rtl/msg_fifo.sv
// Single-clock show-ahead FIFO; dout always presents the head entry.
module msg_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/async_packet_transmitter_q.sv
// Queued datagram serializer: FIFO of whole datagrams, sent LSB-first as strobed packets.
module async_packet_transmitter_q
  import async_link_pkg::*;
#(
  parameter int unsigned MSG_W      = 64,
  parameter int unsigned PKT_W      = DEF_PKT_W,
  parameter int unsigned QDEPTH     = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                          clk_send,
  input  logic                          rst,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [MSG_W-1:0]              datagram_in,
  output logic [PKT_W-1:0]              packet_out,
  output logic                          packet_pulse,
  output logic                          frame_last,
  output logic                          transmit_ctrl,
  output logic [$clog2(QDEPTH+1)-1:0]   queue_count
);

  localparam int unsigned NPKT     = npkt(MSG_W, PKT_W);
  localparam int unsigned BUF_W    = NPKT * PKT_W;
  localparam int unsigned IDX_W    = $clog2(NPKT + 1);
  localparam int unsigned GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPKT - 1);

  tx_state_e        state;
  logic [BUF_W-1:0] shift_buf;
  logic [IDX_W-1:0] pkt_idx;
  logic [GW-1:0]    gap_cnt;

  logic [MSG_W-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;

  assign load_ready = !fifo_full;
  assign fifo_push  = load_valid && load_ready;
  assign fifo_pop   = (state == IDLE) && !fifo_empty;

  msg_fifo #(
    .WIDTH (MSG_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk_send),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (datagram_in),
    .dout  (fifo_dout),
    .count (queue_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Shift buffer is widened to NPKT*PKT_W so the last packet is zero-padded.
  always_ff @(posedge clk_send or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      shift_buf     <= '0;
      pkt_idx       <= '0;
      gap_cnt       <= '0;
      packet_out    <= '0;
      packet_pulse  <= 1'b0;
      frame_last    <= 1'b0;
      transmit_ctrl <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            shift_buf     <= BUF_W'(fifo_dout);
            pkt_idx       <= '0;
            transmit_ctrl <= 1'b1;
            state         <= SEND;
          end
        end
        SEND: begin
          packet_out   <= shift_buf[PKT_W-1:0];
          shift_buf    <= shift_buf >> PKT_W;
          packet_pulse <= 1'b1;
          frame_last   <= (pkt_idx == LAST_IDX);
          state        <= PULSE;
        end
        PULSE: begin
          packet_pulse <= 1'b0;
          pkt_idx      <= pkt_idx + IDX_W'(1);
          if (pkt_idx == LAST_IDX) begin
            transmit_ctrl <= 1'b0;
            if (GAP_CYCLES > 0) begin
              gap_cnt <= GW'(GAP_LOAD);
              state   <= GAP;
            end else begin
              state <= IDLE;
            end
          end else begin
            state <= SEND;
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else               gap_cnt <= gap_cnt - GW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_async_packet_transmitter_q.sv
// Directed bench: 16-bit/gap-2 instance (A) and 12-bit/gap-0 instance (B) sharing clock and reset.
module tb_async_packet_transmitter_q;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic        a_valid, a_ready, a_pulse, a_last, a_tx;
  logic [15:0] a_din;
  logic [5:0]  a_pkt;
  logic [2:0]  a_cnt;
  logic        b_valid, b_ready, b_pulse, b_last, b_tx;
  logic [11:0] b_din;
  logic [5:0]  b_pkt;
  logic [2:0]  b_cnt;

  logic [5:0] a_data_q[$];
  bit         a_last_q[$];
  int         a_cyc_q[$];
  logic [5:0] b_data_q[$];
  bit         b_last_q[$];
  int         b_cyc_q[$];
  int         a_max_cnt = 0;

  async_packet_transmitter_q #(.MSG_W(16), .PKT_W(6), .QDEPTH(4), .GAP_CYCLES(2)) u_a (
    .clk_send(clk), .rst(rst), .load_valid(a_valid), .load_ready(a_ready),
    .datagram_in(a_din), .packet_out(a_pkt), .packet_pulse(a_pulse),
    .frame_last(a_last), .transmit_ctrl(a_tx), .queue_count(a_cnt));

  async_packet_transmitter_q #(.MSG_W(12), .PKT_W(6), .QDEPTH(4), .GAP_CYCLES(0)) u_b (
    .clk_send(clk), .rst(rst), .load_valid(b_valid), .load_ready(b_ready),
    .datagram_in(b_din), .packet_out(b_pkt), .packet_pulse(b_pulse),
    .frame_last(b_last), .transmit_ctrl(b_tx), .queue_count(b_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_pulse) begin a_data_q.push_back(a_pkt); a_last_q.push_back(a_last); a_cyc_q.push_back(cyc); end
    if (b_pulse) begin b_data_q.push_back(b_pkt); b_last_q.push_back(b_last); b_cyc_q.push_back(cyc); end
    if (int'(a_cnt) > a_max_cnt) a_max_cnt = int'(a_cnt);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_a(input logic [15:0] d, output int acc);
    int k = 0;
    a_valid = 1'b1;
    a_din   = d;
    while (!a_ready && k < 200) begin step(); k++; end
    if (!a_ready) check_val("a_push_timeout", 32'd0, 32'd1);
    step();
    acc     = cyc;
    a_valid = 1'b0;
  endtask

  task automatic push_b(input logic [11:0] d, output int acc);
    int k = 0;
    b_valid = 1'b1;
    b_din   = d;
    while (!b_ready && k < 200) begin step(); k++; end
    if (!b_ready) check_val("b_push_timeout", 32'd0, 32'd1);
    step();
    acc     = cyc;
    b_valid = 1'b0;
  endtask

  task automatic wait_a(input int n, input int budget);
    int k = 0;
    while (a_data_q.size() < n && k < budget) begin step(); k++; end
    if (a_data_q.size() < n) check_val("a_pulse_timeout", a_data_q.size(), n);
  endtask

  task automatic wait_b(input int n, input int budget);
    int k = 0;
    while (b_data_q.size() < n && k < budget) begin step(); k++; end
    if (b_data_q.size() < n) check_val("b_pulse_timeout", b_data_q.size(), n);
  endtask

  task automatic clear_a();
    a_data_q.delete(); a_last_q.delete(); a_cyc_q.delete();
  endtask

  task automatic check_frames_a(input logic [15:0] dl[], input string tag);
    for (int f = 0; f < dl.size(); f++)
      for (int p = 0; p < 3; p++) begin
        logic [15:0] sh;
        sh = dl[f] >> (6 * p);
        check_val($sformatf("%s_data_f%0d_p%0d", tag, f, p), a_data_q[3*f+p], sh[5:0]);
        check_val($sformatf("%s_last_f%0d_p%0d", tag, f, p), a_last_q[3*f+p], (p == 2));
      end
  endtask

  initial begin
    int acc, acc0;
    int acc_l[6];
    int n;
    logic [15:0] dl6[] = '{16'h1234, 16'hBEEF, 16'h0F0F, 16'hFFFF, 16'h8001, 16'h5A5A};
    logic [15:0] dl4[] = '{16'h0001, 16'h0FC0, 16'hF03F, 16'h7777};

    // Reset, with a push offered that must be discarded
    rst = 1'b1; a_valid = 1'b1; a_din = 16'hDEAD; b_valid = 1'b0; b_din = '0;
    step(); step(); step();
    check_val("rst_a_pkt", a_pkt, 6'h00);
    check_val("rst_a_pulse", a_pulse, 1'b0);
    check_val("rst_a_last", a_last, 1'b0);
    check_val("rst_a_tx", a_tx, 1'b0);
    check_val("rst_a_cnt", a_cnt, 3'd0);
    check_val("rst_a_ready", a_ready, 1'b1);
    check_val("rst_b_ready", b_ready, 1'b1);
    a_valid = 1'b0;
    step();
    rst = 1'b0;
    repeat (10) step();
    check_val("rst_push_discarded_cnt", a_cnt, 3'd0);
    check_val("rst_push_discarded_pulses", a_data_q.size(), 0);

    // Single frame 0xABCD -> 0x0D, 0x2F, 0x0A
    clear_a();
    push_a(16'hABCD, acc);
    wait_a(3, 60);
    check_val("t1_p0", a_data_q[0], 6'h0D);
    check_val("t1_p1", a_data_q[1], 6'h2F);
    check_val("t1_p2", a_data_q[2], 6'h0A);
    check_val("t1_last0", a_last_q[0], 1'b0);
    check_val("t1_last1", a_last_q[1], 1'b0);
    check_val("t1_last2", a_last_q[2], 1'b1);
    check_val("t1_first_latency", a_cyc_q[0] - acc, 2);
    check_val("t1_pkt_spacing", a_cyc_q[1] - a_cyc_q[0], 2);
    repeat (8) step();
    check_val("t1_hold_pkt", a_pkt, 6'h0A);
    check_val("t1_hold_last", a_last, 1'b1);
    check_val("t1_idle_tx", a_tx, 1'b0);
    check_val("t1_no_extra", a_data_q.size(), 3);

    // Six back-to-back pushes: one in flight, four queued, sixth held off
    clear_a();
    a_max_cnt = 0;
    for (int i = 0; i < 5; i++) push_a(dl6[i], acc_l[i]);
    check_val("t2_full_cnt", a_cnt, 3'd4);
    check_val("t2_full_ready", a_ready, 1'b0);
    push_a(dl6[5], acc_l[5]);
    for (int i = 1; i < 5; i++) check_val($sformatf("t2_acc%0d", i), acc_l[i] - acc_l[0], i);
    check_val("t2_acc5_after_pop", acc_l[5] - acc_l[0], 11);
    wait_a(18, 200);
    check_frames_a(dl6, "t2");
    check_val("t2_first_latency", a_cyc_q[0] - acc_l[0], 2);
    for (int f = 1; f < 6; f++)
      check_val($sformatf("t2_period_f%0d", f), a_cyc_q[3*f] - a_cyc_q[3*(f-1)], 9);
    check_val("t2_max_cnt", a_max_cnt, 4);
    repeat (15) step();

    // Push coinciding with a pop at count 2
    clear_a();
    push_a(dl4[0], acc0);
    push_a(dl4[1], acc);
    push_a(dl4[2], acc);
    check_val("t3_cnt_after3", a_cnt, 3'd2);
    n = 0;
    while (cyc < acc0 + 9 && n < 50) begin step(); n++; end
    check_val("t3_cnt_pre", a_cnt, 3'd2);
    a_valid = 1'b1; a_din = dl4[3];
    step();
    a_valid = 1'b0;
    check_val("t3_cnt_pushpop", a_cnt, 3'd2);
    wait_a(12, 200);
    check_frames_a(dl4, "t3");
    repeat (20) step();
    check_val("t3_no_dup", a_data_q.size(), 12);

    // Reset during the second packet with two datagrams queued
    clear_a();
    push_a(16'h1111, acc);
    push_a(16'h2222, acc);
    push_a(16'h3333, acc);
    wait_a(2, 40);
    check_val("t4_cnt_before_rst", a_cnt, 3'd2);
    rst = 1'b1;
    #1;
    check_val("t4_rst_pkt", a_pkt, 6'h00);
    check_val("t4_rst_pulse", a_pulse, 1'b0);
    check_val("t4_rst_last", a_last, 1'b0);
    check_val("t4_rst_tx", a_tx, 1'b0);
    check_val("t4_rst_cnt", a_cnt, 3'd0);
    step(); step();
    rst = 1'b0;
    n = a_data_q.size();
    repeat (30) step();
    check_val("t4_no_pulse_after_rst", a_data_q.size(), n);
    check_val("t4_cnt_after_rst", a_cnt, 3'd0);

    // Instance B: 12-bit datagrams, no gap
    push_b(12'hFC3, acc);
    push_b(12'h041, acc0);
    wait_b(4, 60);
    check_val("t5_p0", b_data_q[0], 6'h03);
    check_val("t5_p1", b_data_q[1], 6'h3F);
    check_val("t5_p2", b_data_q[2], 6'h01);
    check_val("t5_p3", b_data_q[3], 6'h01);
    check_val("t5_last1", b_last_q[1], 1'b1);
    check_val("t5_last2", b_last_q[2], 1'b0);
    check_val("t5_last3", b_last_q[3], 1'b1);
    check_val("t5_first_latency", b_cyc_q[0] - acc, 2);
    check_val("t5_period", b_cyc_q[2] - b_cyc_q[0], 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
